// File: rtl/cube_fb_if.sv
// Frame memory read port shared between the VGA writer and the readback block.
// The grant comes from an external arbiter; data returns RD_LATENCY cycles after a read.
interface cube_fb_if #(
  parameter int FB_ADDR_W = 15
) ();
  logic                 mem_req;
  logic                 mem_gnt;
  logic [FB_ADDR_W-1:0] mem_addr;
  logic                 mem_rd_en;
  logic [23:0]          mem_q;

  modport master (
    output mem_req, mem_addr, mem_rd_en,
    input  mem_gnt, mem_q
  );

  modport slave (
    input  mem_req, mem_addr, mem_rd_en,
    output mem_gnt, mem_q
  );
endinterface

// File: rtl/cube_fb_readback.sv
// Reads the anchor pixel of all 54 stickers back from the frame memory and decodes them to colour codes.
// Optional expected-colour compare is enabled with `define CUBE_READBACK_CMP_EN.
module cube_fb_readback #(
  parameter int FB_ADDR_W    = 15,
  parameter int RD_LATENCY   = 1,
  parameter int GRID_W       = 64,
  parameter int NUM_STICKERS = 54
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  cube_fb_if.master        mem,
  output logic             busy,
  output logic             done,
  output logic [161:0]     colors,
  output logic             err,
  output logic [5:0]       err_idx
`ifdef CUBE_READBACK_CMP_EN
  ,
  input  logic [161:0]     expected_color,
  output logic             mismatch,
  output logic [5:0]       mismatch_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [5:0] LAST_IDX = 6'(NUM_STICKERS - 1);
  localparam logic [5:0] ALL_CAPT = 6'(NUM_STICKERS);

  state_t                  state;
  logic [5:0]              issue_idx;
  logic [5:0]              cap_idx;
  logic [RD_LATENCY-1:0]   vld_pipe;
  logic                    err_acc;
  logic [5:0]              first_err;
  logic [FB_ADDR_W-1:0]    addr_hold;
  logic [161:0]            shadow;

  logic                    cap_vld;
  logic                    cap_bad;
  logic [2:0]              cap_code;
  logic [7:0]              cap_base;

  // Anchor cells: a 3x3 face above, four faces in a row, a 3x3 face below, 3-cell pitch.
  function automatic logic [FB_ADDR_W-1:0] anchor_addr(input logic [5:0] k);
    int unsigned kk;
    int unsigned j;
    int unsigned row;
    int unsigned col;
    kk = 32'(k);
    if (kk < 9) begin
      row = 10 + 3 * (kk / 3);
      col = 12 + 3 * (kk % 3);
    end else if (kk < 45) begin
      j   = kk - 9;
      row = 20 + 3 * (j / 12);
      col = 2 + 3 * ((j % 12) % 3) + 10 * ((j % 12) / 3);
    end else begin
      j   = kk - 45;
      row = 30 + 3 * (j / 3);
      col = 12 + 3 * (j % 3);
    end
    return FB_ADDR_W'(row * GRID_W + col);
  endfunction

  // Returns {undecodable, code}; only exact palette words decode.
  function automatic logic [3:0] decode_rgb(input logic [23:0] rgb);
    case (rgb)
      24'hFFFFFF: return 4'b0_000;
      24'hFF4000: return 4'b0_001;
      24'h00FF00: return 4'b0_010;
      24'hFF0000: return 4'b0_011;
      24'h0000FF: return 4'b0_100;
      24'hFFFF00: return 4'b0_101;
      default:    return 4'b1_111;
    endcase
  endfunction

  // The grant is a same-cycle input, so the read strobe and its address cannot be registered.
  assign mem.mem_rd_en = (state == ISSUE) && mem.mem_gnt;
  assign mem.mem_addr  = mem.mem_rd_en ? anchor_addr(issue_idx) : addr_hold;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cap_vld             = vld_pipe[RD_LATENCY-1];
    {cap_bad, cap_code} = decode_rgb(mem.mem_q);
    cap_base            = 8'(cap_idx) * 8'd3;
  end

`ifdef CUBE_READBACK_CMP_EN
  logic [161:0] exp_q;
  logic [5:0]   diff_cnt;

  // At most NUM_STICKERS fields can differ, so the count saturates at 54 by construction.
  always_comb begin
    diff_cnt = '0;
    for (int i = 0; i < NUM_STICKERS; i++) begin
      if (shadow[3*i +: 3] != exp_q[3*i +: 3]) diff_cnt = diff_cnt + 6'd1;
    end
  end
`endif

  // NOTE: shadow is a scratch store fully rewritten every scan, so it carries no reset.
  always_ff @(posedge clk) begin
    if (cap_vld) shadow[cap_base +: 3] <= cap_code;
  end

  // NOTE: all state uses non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      colors    <= '0;
      err       <= 1'b0;
      err_idx   <= '0;
      mem.mem_req <= 1'b0;
      issue_idx <= '0;
      cap_idx   <= '0;
      vld_pipe  <= '0;
      err_acc   <= 1'b0;
      first_err <= '0;
      addr_hold <= '0;
`ifdef CUBE_READBACK_CMP_EN
      exp_q        <= '0;
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
`endif
    end else begin
      done      <= 1'b0;
      addr_hold <= mem.mem_addr;

      vld_pipe[0] <= mem.mem_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];

      // Captures follow the returning data, independent of the current grant.
      if (cap_vld) begin
        cap_idx <= cap_idx + 6'd1;
        if (cap_bad && !err_acc) begin
          err_acc   <= 1'b1;
          first_err <= cap_idx;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= ISSUE;
            busy        <= 1'b1;
            mem.mem_req <= 1'b1;
            issue_idx   <= '0;
            cap_idx     <= '0;
            err_acc     <= 1'b0;
            first_err   <= '0;
`ifdef CUBE_READBACK_CMP_EN
            exp_q       <= expected_color;
`endif
          end
        end
        ISSUE: begin
          if (mem.mem_rd_en) begin
            issue_idx <= issue_idx + 6'd1;
            if (issue_idx == LAST_IDX) begin
              state       <= DRAIN;
              mem.mem_req <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Publishing here makes the outputs valid in the same cycle as the done pulse.
          if (cap_idx == ALL_CAPT) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            colors  <= shadow;
            err     <= err_acc;
            err_idx <= first_err;
`ifdef CUBE_READBACK_CMP_EN
            mismatch     <= (diff_cnt != 6'd0);
            mismatch_cnt <= diff_cnt;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_fb_readback.sv
// Directed bench for cube_fb_readback: frame memory model, grant control and immediate-assert checks.
// Define CUBE_READBACK_CMP_EN to also exercise the expected-colour compare.
module tb_cube_fb_readback;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         gnt = 1'b0;
  logic         busy;
  logic         done;
  logic [161:0] colors;
  logic         err;
  logic [5:0]   err_idx;
  logic [23:0]  mem_q_r = '0;
`ifdef CUBE_READBACK_CMP_EN
  logic [161:0] expected_color = '0;
  logic         mismatch;
  logic [5:0]   mismatch_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cube_fb_if #(.FB_ADDR_W(15)) mif ();
  assign mif.mem_gnt = gnt;
  assign mif.mem_q   = mem_q_r;

  cube_fb_readback #(
    .FB_ADDR_W(15), .RD_LATENCY(1), .GRID_W(64), .NUM_STICKERS(54)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mem(mif.master),
    .busy(busy), .done(done), .colors(colors), .err(err), .err_idx(err_idx)
`ifdef CUBE_READBACK_CMP_EN
    , .expected_color(expected_color), .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
`endif
  );

  // Frame memory with a one-cycle read latency.
  logic [23:0] fb [0:32767];
  always @(posedge clk) if (mif.mem_rd_en) mem_q_r <= fb[mif.mem_addr];

  // Read-port monitor, sampled away from the active edge.
  logic        mon_en = 1'b0;
  int          viol = 0;
  logic [14:0] addr_q [$];
  always @(negedge clk) begin
    if (mon_en && mif.mem_rd_en) begin
      if (!gnt) viol++;
      addr_q.push_back(mif.mem_addr);
    end
  end

  logic [14:0]  exp_anchor [54];
  logic [23:0]  palette [6];
  logic [161:0] exp_colors;
  logic [161:0] exp_err_colors;

  task automatic check(input string tag, input logic [161:0] obs, input logic [161:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Returns cycles from the start-sampling edge to the cycle where done is seen.
  task automatic wait_done(input bit toggle, output int n);
    n = 1;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      if (toggle) gnt = ~gnt;
      n++;
    end
  endtask

  task automatic check_addrs(input string tag);
    int bad;
    bad = 0;
    check({tag, "_cnt"}, 162'(addr_q.size()), 162'd54);
    for (int i = 0; i < 54 && i < addr_q.size(); i++)
      if (addr_q[i] !== exp_anchor[i]) bad++;
    check({tag, "_order"}, 162'(bad), 162'd0);
    check({tag, "_a0"}, 162'(addr_q[0]), 162'd652);
    check({tag, "_a1"}, 162'(addr_q[1]), 162'd655);
    check({tag, "_a2"}, 162'(addr_q[2]), 162'd658);
    check({tag, "_a3"}, 162'(addr_q[3]), 162'd844);
  endtask

  initial begin
    int rows_a [3] = '{10, 13, 16};
    int rows_b [3] = '{20, 23, 26};
    int rows_c [3] = '{30, 33, 36};
    int cols_a [3] = '{12, 15, 18};
    int cols_b [12] = '{2, 5, 8, 12, 15, 18, 22, 25, 28, 32, 35, 38};
    int k;
    int n;
    int dcnt;

    palette = '{24'hFFFFFF, 24'hFF4000, 24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFFFF00};
    k = 0;
    foreach (rows_a[r]) foreach (cols_a[c]) begin exp_anchor[k] = 15'(rows_a[r] * 64 + cols_a[c]); k++; end
    foreach (rows_b[r]) foreach (cols_b[c]) begin exp_anchor[k] = 15'(rows_b[r] * 64 + cols_b[c]); k++; end
    foreach (rows_c[r]) foreach (cols_a[c]) begin exp_anchor[k] = 15'(rows_c[r] * 64 + cols_a[c]); k++; end

    for (int i = 0; i < 32768; i++) fb[i] = 24'h123456;
    exp_colors = '0;
    for (int i = 0; i < 54; i++) begin
      fb[exp_anchor[i]]      = palette[i % 6];
      exp_colors[3*i +: 3]   = 3'(i % 6);
    end
    exp_err_colors          = exp_colors;
    exp_err_colors[62:60]   = 3'b111;
    exp_err_colors[122:120] = 3'b111;

    // Reset state
    #12;
    check("rst_busy", 162'(busy), 162'd0);
    check("rst_done", 162'(done), 162'd0);
    check("rst_req", 162'(mif.mem_req), 162'd0);
    check("rst_rd_en", 162'(mif.mem_rd_en), 162'd0);
    check("rst_colors", colors, 162'd0);
    check("rst_err", 162'({err, err_idx}), 162'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Held grant: full-latency scan
    gnt = 1'b1;
`ifdef CUBE_READBACK_CMP_EN
    expected_color        = exp_colors;
    expected_color[17:15] = 3'b000;
`endif
    addr_q.delete();
    mon_en = 1'b1;
    pulse_start();
    check("a_busy", 162'(busy), 162'd1);
    check("a_req", 162'(mif.mem_req), 162'd1);
    wait_done(1'b0, n);
    mon_en = 1'b0;
    check("a_done_seen", 162'(done), 162'd1);
    check("a_latency", 162'(n), 162'd57);
    check("a_busy_done", 162'(busy), 162'd0);
    check("a_k0", 162'(colors[2:0]), 162'd0);
    check("a_k1", 162'(colors[5:3]), 162'd1);
    check("a_k53", 162'(colors[161:159]), 162'd5);
    check("a_colors", colors, exp_colors);
    check("a_err", 162'(err), 162'd0);
    check("a_viol", 162'(viol), 162'd0);
    check_addrs("a_addr");
`ifdef CUBE_READBACK_CMP_EN
    check("a_mismatch", 162'(mismatch), 162'd1);
    check("a_mismatch_cnt", 162'(mismatch_cnt), 162'd1);
    expected_color = exp_colors;
`endif
    @(posedge clk); #1;
    check("a_done_pulse", 162'(done), 162'd0);

    // Toggling grant 1,0,1,0...
    addr_q.delete();
    viol = 0;
    mon_en = 1'b1;
    pulse_start();
    wait_done(1'b1, n);
    mon_en = 1'b0;
    gnt = 1'b1;
    check("b_done_seen", 162'(done), 162'd1);
    check("b_viol", 162'(viol), 162'd0);
    check("b_colors", colors, exp_colors);
    check_addrs("b_addr");
`ifdef CUBE_READBACK_CMP_EN
    check("b_mismatch", 162'(mismatch), 162'd0);
    check("b_mismatch_cnt", 162'(mismatch_cnt), 162'd0);
`endif

    // Undecodable pixels at stickers 20 and 40
    fb[exp_anchor[20]] = 24'hFF00FF;
    fb[exp_anchor[40]] = 24'h000000;
    pulse_start();
    wait_done(1'b0, n);
    check("c_done_seen", 162'(done), 162'd1);
    check("c_k20", 162'(colors[62:60]), 162'd7);
    check("c_k40", 162'(colors[122:120]), 162'd7);
    check("c_colors", colors, exp_err_colors);
    check("c_err", 162'(err), 162'd1);
    check("c_err_idx", 162'(err_idx), 162'd20);
    fb[exp_anchor[20]] = palette[20 % 6];
    fb[exp_anchor[40]] = palette[40 % 6];

    // Second start while busy is dropped; outputs hold until the new done
    pulse_start();
    repeat (9) @(posedge clk);
    #1;
    check("d_colors_stable", colors, exp_err_colors);
    check("d_err_stable", 162'({err, err_idx}), 162'({1'b1, 6'd20}));
    start = 1'b1;
    dcnt = 0;
    repeat (150) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) dcnt++;
    end
    check("d_done_count", 162'(dcnt), 162'd1);
    check("d_colors", colors, exp_colors);
    check("d_err", 162'(err), 162'd0);
    pulse_start();
    wait_done(1'b0, n);
    check("d_fresh_latency", 162'(n), 162'd57);
    check("d_fresh_colors", colors, exp_colors);

    // Reset 30 cycles into a scan
    pulse_start();
    repeat (29) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("e_busy", 162'(busy), 162'd0);
    check("e_done", 162'(done), 162'd0);
    check("e_req", 162'(mif.mem_req), 162'd0);
    check("e_colors", colors, 162'd0);
    @(posedge clk); #1 rst = 1'b1;
    pulse_start();
    wait_done(1'b0, n);
    check("e_latency", 162'(n), 162'd57);
    check("e_colors_after", colors, exp_colors);
    check("e_err_after", 162'(err), 162'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
